alu_mc: RTL

//   Multi-cycle, handshaked successor to the combinational Hack ALU for the CPU datapath.

---
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operand request channel plus result/flags channel.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic             op_mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;

  modport master (
    output in_valid, x, y, ctrl, op_mul, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );

  modport slave (
    input  in_valid, x, y, ctrl, op_mul, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle handshaked Hack ALU with registered result and carry/overflow flags.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (op_mul).
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic     clock,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam int         CNT_W  = $clog2(WIDTH);
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d;

  logic [WIDTH-1:0] x0, y0, x2, y2, r_alu, o_alu;
  logic [WIDTH:0]   sum;
  logic             is_mul, accept;

  // Hack pre-processing: zero then optionally invert each operand.
  assign x0    = bus.ctrl[5] ? '0 : bus.x;
  assign x2    = bus.ctrl[4] ? ~x0 : x0;
  assign y0    = bus.ctrl[3] ? '0 : bus.y;
  assign y2    = bus.ctrl[2] ? ~y0 : y0;
  assign sum   = {1'b0, x2} + {1'b0, y2};
  assign r_alu = bus.ctrl[1] ? sum[WIDTH-1:0] : (x2 & y2);
  assign o_alu = bus.ctrl[0] ? ~r_alu : r_alu;

`ifdef ALU_MUL_EN
  assign is_mul = bus.op_mul;
`else
  assign is_mul = 1'b0;
`endif

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cy        = cy_q;
  assign bus.ov        = ov_q;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0]   mplier_q, mplier_d, r_mul, o_mul;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               no_q, no_d;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign r_mul   = acc_nxt[WIDTH-1:0];
  assign o_mul   = no_q ? ~r_mul : r_mul;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept && is_mul) begin
`ifdef ALU_MUL_EN
          state_d  = S_MUL;
          mcand_d  = {{WIDTH{1'b0}}, x2};
          mplier_d = y2;
          acc_d    = '0;
          cnt_d    = '0;
          no_d     = bus.ctrl[0];
`endif
        end else if (accept) begin
          state_d = S_DONE;
          out_d   = o_alu;
          zr_d    = (o_alu == '0);
          ng_d    = o_alu[WIDTH-1];
          cy_d    = bus.ctrl[1] && sum[WIDTH];
          ov_d    = bus.ctrl[1] && (x2[WIDTH-1] == y2[WIDTH-1]) && (r_alu[WIDTH-1] != x2[WIDTH-1]);
        end else if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        // One partial product per cycle; the final add is folded into the DONE transition.
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          out_d   = o_mul;
          zr_d    = (o_mul == '0);
          ng_d    = o_mul[WIDTH-1];
          cy_d    = |acc_nxt[2*WIDTH-1:WIDTH];
          ov_d    = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      no_q     <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      no_q     <= no_d;
    end
  end
`endif
endmodule
